ir_cmd_ctrl: RTL and testbench

Command stage directly downstream of the NEC infrared receiver `remote_rcv`. It consumes the receiver's decoded key byte (`data`/`data_en`) and its repeat-frame strobe (`repeat_en`), and turns them into a held motion command and a speed level for the smart-car motor controller. A motion key stays active while the user holds it, because repeat frames keep it alive. The block returns to STOP when repeat frames stop arriving.

---
 rtl/ir_cmd_pkg.sv | 49 ++++
 rtl/hold_timer.sv | 32 +++
 rtl/ir_cmd_ctrl.sv | 100 ++++++++++
 tb/tb_ir_cmd_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/ir_cmd_pkg.sv
// ir_cmd_pkg: shared definitions for the IR command stage.
//   - NEC key codes recognised by ir_cmd_ctrl
//   - motion command encoding driven to the motor controller
//   - FSM state type
//   - hold_cycles(): hold timeout in sys_clk cycles
package ir_cmd_pkg;

  localparam logic [7:0] K_FWD   = 8'h18;
  localparam logic [7:0] K_BWD   = 8'h52;
  localparam logic [7:0] K_LEFT  = 8'h08;
  localparam logic [7:0] K_RIGHT = 8'h5A;
  localparam logic [7:0] K_STOP  = 8'h1C;
  localparam logic [7:0] K_SPDUP = 8'h15;
  localparam logic [7:0] K_SPDDN = 8'h07;

  typedef enum logic [2:0] {
    M_STOP  = 3'd0,
    M_FWD   = 3'd1,
    M_BWD   = 3'd2,
    M_LEFT  = 3'd3,
    M_RIGHT = 3'd4
  } motion_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic int unsigned hold_cycles(input int unsigned clk_freq,
                                              input int unsigned hold_ms);
    return clk_freq / 1000 * hold_ms;
  endfunction

  function automatic logic is_motion_key(input logic [7:0] code);
    return (code == K_FWD) || (code == K_BWD) ||
           (code == K_LEFT) || (code == K_RIGHT);
  endfunction

  function automatic motion_t key_to_motion(input logic [7:0] code);
    case (code)
      K_FWD:   return M_FWD;
      K_BWD:   return M_BWD;
      K_LEFT:  return M_LEFT;
      K_RIGHT: return M_RIGHT;
      default: return M_STOP;
    endcase
  endfunction

endpackage

// File: rtl/hold_timer.sv
// hold_timer: loadable down-counter that times how long a held key stays alive.
//   clk     : clock, rising edge
//   rst     : asynchronous active-high reset, counter to 0
//   load    : reload the counter to CYCLES-1
//   expired : high while the counter is 0
// Without load the counter decrements and rests at 0.
module hold_timer #(
  parameter int unsigned CYCLES = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic expired
);

  localparam int unsigned W = (CYCLES > 1) ? $clog2(CYCLES + 1) : 1;

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= W'(CYCLES - 1);
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/ir_cmd_ctrl.sv
// ir_cmd_ctrl: turns decoded NEC key frames into a held motion command and a
// speed level for the motor controller.
//   sys_clk   : clock, rising edge
//   sys_rst   : asynchronous active-high reset
//   data_en   : one-cycle strobe, new frame key code on data
//   data      : key code
//   repeat_en : one-cycle strobe, NEC repeat frame received
//   motion    : current motion command (ir_cmd_pkg::motion_t encoding)
//   speed_lvl : speed level 0..3
//   active    : high while a motion command is held (state RUN)
//   cmd_valid : one-cycle pulse whenever motion or speed_lvl changes
module ir_cmd_ctrl
  import ir_cmd_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 50_000_000,
  parameter int unsigned HOLD_MS  = 120
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       data_en,
  input  logic [7:0] data,
  input  logic       repeat_en,
  output logic [2:0] motion,
  output logic [1:0] speed_lvl,
  output logic       active,
  output logic       cmd_valid
);

  localparam int unsigned HOLD_CYC = hold_cycles(CLK_FREQ, HOLD_MS);

  state_t     state_q, state_d;
  motion_t    motion_q, motion_d;
  logic [1:0] speed_q, speed_d;
  logic       cmd_valid_q, cmd_valid_d;
  logic       load;
  logic       expired;

  hold_timer #(
    .CYCLES(HOLD_CYC)
  ) u_hold_timer (
    .clk     (sys_clk),
    .rst     (sys_rst),
    .load    (load),
    .expired (expired)
  );

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q     <= IDLE;
      motion_q    <= M_STOP;
      speed_q     <= 2'd1;
      cmd_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      motion_q    <= motion_d;
      speed_q     <= speed_d;
      cmd_valid_q <= cmd_valid_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    motion_d = motion_q;
    speed_d  = speed_q;
    load     = 1'b0;

    // data_en wins over a coincident repeat_en; repeats only matter in RUN.
    if (data_en) begin
      if (is_motion_key(data)) begin
        motion_d = key_to_motion(data);
        state_d  = RUN;
        load     = 1'b1;
      end else if (data == K_STOP) begin
        motion_d = M_STOP;
        state_d  = IDLE;
      end else if (data == K_SPDUP) begin
        if (speed_q != 2'd3) speed_d = speed_q + 2'd1;
      end else if (data == K_SPDDN) begin
        if (speed_q != 2'd0) speed_d = speed_q - 2'd1;
      end
    end else if (repeat_en && (state_q == RUN)) begin
      load = 1'b1;
    end

    // Speed keys and unknown codes are not reloads, so a timeout can land on
    // the same cycle as a speed step.
    if ((state_q == RUN) && (state_d == RUN) && !load && expired) begin
      motion_d = M_STOP;
      state_d  = IDLE;
    end

    cmd_valid_d = (motion_d != motion_q) || (speed_d != speed_q);
  end

  assign motion    = motion_q;
  assign speed_lvl = speed_q;
  assign active    = (state_q == RUN);
  assign cmd_valid = cmd_valid_q;

endmodule

// File: tb/tb_ir_cmd_ctrl.sv
// tb_ir_cmd_ctrl: directed bench for ir_cmd_ctrl with CLK_FREQ=10_000,
// HOLD_MS=2 (hold timeout of 20 cycles). Inputs change and outputs are
// sampled on the falling clock edge.
module tb_ir_cmd_ctrl;

  logic       sys_clk = 1'b0;
  logic       sys_rst;
  logic       data_en;
  logic [7:0] data;
  logic       repeat_en;
  logic [2:0] motion;
  logic [1:0] speed_lvl;
  logic       active;
  logic       cmd_valid;

  int n_tests = 0;
  int n_fail  = 0;
  int p;

  ir_cmd_ctrl #(
    .CLK_FREQ(10_000),
    .HOLD_MS (2)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .data_en  (data_en),
    .data     (data),
    .repeat_en(repeat_en),
    .motion   (motion),
    .speed_lvl(speed_lvl),
    .active   (active),
    .cmd_valid(cmd_valid)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance n falling edges, counting cmd_valid pulses seen.
  task automatic run_cycles(input int n, output int pulses);
    pulses = 0;
    repeat (n) begin
      @(negedge sys_clk);
      if (cmd_valid) pulses++;
    end
  endtask

  // Called at a falling edge; returns at the falling edge after the sampling edge.
  task automatic send_key(input logic [7:0] code);
    data_en = 1'b1;
    data    = code;
    @(negedge sys_clk);
    data_en = 1'b0;
    data    = 8'h00;
  endtask

  task automatic send_rep();
    repeat_en = 1'b1;
    @(negedge sys_clk);
    repeat_en = 1'b0;
  endtask

  task automatic send_both(input logic [7:0] code);
    data_en   = 1'b1;
    repeat_en = 1'b1;
    data      = code;
    @(negedge sys_clk);
    data_en   = 1'b0;
    repeat_en = 1'b0;
    data      = 8'h00;
  endtask

  initial begin
    #100_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    sys_rst   = 1'b1;
    data_en   = 1'b0;
    data      = 8'h00;
    repeat_en = 1'b0;
    repeat (2) @(negedge sys_clk);
    sys_rst = 1'b0;
    @(negedge sys_clk);

    check("rst_motion", motion, 0);
    check("rst_speed", speed_lvl, 1);
    check("rst_active", active, 0);
    check("rst_cmd_valid", cmd_valid, 0);

    // Forward press, then timeout 20 cycles after the strobe.
    send_key(8'h18);
    check("fwd_motion", motion, 1);
    check("fwd_active", active, 1);
    check("fwd_cmd_valid", cmd_valid, 1);
    run_cycles(19, p);
    check("fwd_hold_motion", motion, 1);
    check("fwd_hold_pulses", p, 0);
    run_cycles(1, p);
    check("fwd_to_motion", motion, 0);
    check("fwd_to_active", active, 0);
    check("fwd_to_cmd_valid", cmd_valid, 1);
    run_cycles(1, p);
    check("fwd_to_pulse_len", cmd_valid, 0);

    // Backward held by five repeats spaced 15 cycles apart.
    send_key(8'h52);
    check("bwd_motion", motion, 2);
    for (int i = 0; i < 5; i++) begin
      run_cycles(14, p);
      check("bwd_gap_pulses", p, 0);
      send_rep();
      check("bwd_rep_motion", motion, 2);
      check("bwd_rep_cmd_valid", cmd_valid, 0);
    end
    run_cycles(19, p);
    check("bwd_tail_motion", motion, 2);
    check("bwd_tail_pulses", p, 0);
    run_cycles(1, p);
    check("bwd_to_motion", motion, 0);
    check("bwd_to_cmd_valid", cmd_valid, 1);
    run_cycles(2, p);

    // Speed up with saturation; a repeat never steps speed.
    send_key(8'h15);
    check("spdup1", speed_lvl, 2);
    check("spdup1_cv", cmd_valid, 1);
    send_key(8'h15);
    check("spdup2", speed_lvl, 3);
    check("spdup2_cv", cmd_valid, 1);
    send_key(8'h15);
    check("spdup3", speed_lvl, 3);
    check("spdup3_cv", cmd_valid, 0);
    send_key(8'h15);
    check("spdup4", speed_lvl, 3);
    check("spdup4_cv", cmd_valid, 0);
    send_rep();
    check("spd_rep", speed_lvl, 3);
    check("spd_rep_cv", cmd_valid, 0);
    send_key(8'h07);
    check("spddn1", speed_lvl, 2);
    send_key(8'h07);
    check("spddn2", speed_lvl, 1);
    send_key(8'h07);
    check("spddn3", speed_lvl, 0);
    check("spddn3_cv", cmd_valid, 1);
    send_key(8'h07);
    check("spddn4", speed_lvl, 0);
    check("spddn4_cv", cmd_valid, 0);
    check("spd_motion", motion, 0);

    // data_en beats coincident repeat_en; the motion key reloads the timer.
    send_key(8'h08);
    check("left_motion", motion, 3);
    run_cycles(5, p);
    send_both(8'h5A);
    check("both_motion", motion, 4);
    check("both_cmd_valid", cmd_valid, 1);
    check("both_active", active, 1);
    run_cycles(18, p);
    check("both_reload_motion", motion, 4);
    check("both_reload_pulses", p, 0);
    send_key(8'h1C);
    check("stop_motion", motion, 0);
    check("stop_active", active, 0);
    check("stop_cmd_valid", cmd_valid, 1);
    run_cycles(2, p);

    // Unknown code in IDLE and in RUN.
    send_key(8'h33);
    check("unk_idle_motion", motion, 0);
    check("unk_idle_speed", speed_lvl, 0);
    check("unk_idle_active", active, 0);
    check("unk_idle_cv", cmd_valid, 0);
    send_key(8'h18);
    run_cycles(4, p);
    send_key(8'h33);
    check("unk_run_motion", motion, 1);
    check("unk_run_cv", cmd_valid, 0);
    run_cycles(14, p);
    check("unk_run_hold", motion, 1);
    check("unk_run_pulses", p, 0);
    run_cycles(1, p);
    check("unk_run_to", motion, 0);
    run_cycles(2, p);

    // Asynchronous reset in the middle of RUN.
    send_key(8'h15);
    send_key(8'h15);
    send_key(8'h15);
    check("pre_rst_speed", speed_lvl, 3);
    send_key(8'h18);
    run_cycles(3, p);
    #2;
    sys_rst = 1'b1;
    #1;
    check("arst_motion", motion, 0);
    check("arst_speed", speed_lvl, 1);
    check("arst_active", active, 0);
    check("arst_cmd_valid", cmd_valid, 0);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    @(negedge sys_clk);
    send_key(8'h18);
    check("post_rst_motion", motion, 1);
    check("post_rst_active", active, 1);
    check("post_rst_cv", cmd_valid, 1);
    check("post_rst_speed", speed_lvl, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
